// File: rtl/pe_start_fifo_pkg.sv
// Shared constants and helpers for the pe_start_fifo block.
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH / DEFAULT_DEPTH : parameter defaults
//   cnt_width(depth) : bits needed to hold an occupancy count of 0..depth
package pe_start_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 1;
    localparam int DEFAULT_ADDR_WIDTH = 1;
    localparam int DEFAULT_DEPTH      = 2;

    // The count must reach DEPTH itself (not DEPTH-1), hence depth+1 states.
    function automatic int cnt_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pe_start_fifo_srl.sv
// Token storage for pe_start_fifo: a write-enabled shift register with an
// addressed combinational read port. Holds no reset; validity of entries is
// tracked entirely by the controller's occupancy count.
//   clk      : clock
//   shift_en : shift all entries up by one and load din into entry 0
//   din      : token to load
//   addr     : entry to present on dout (entry 0 = newest)
//   dout     : selected entry, combinational
module pe_start_fifo_srl
    import pe_start_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] sr_reg [DEPTH];
    logic [DEPTH-1:0]      hit;

    always_ff @(posedge clk) begin
        if (shift_en) begin
            sr_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr_reg[i] <= sr_reg[i-1];
            end
        end
    end

    // One-hot address decode; addresses beyond DEPTH-1 select nothing and
    // read as zero (they are never used while the FIFO holds data).
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_decode
            assign hit[gi] = (addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                dout = sr_reg[i];
            end
        end
    end

endmodule

// File: rtl/pe_start_fifo.sv
// Small shift-register FIFO used to pass start tokens between processes.
// Control only: accept logic, occupancy count, registered flags and the read
// address; the storage lives in pe_start_fifo_srl.
//   clk, reset   : clock, synchronous active-high reset
//   if_write_ce, if_write, if_din, if_full_n  : producer side
//   if_read_ce,  if_read,  if_dout, if_empty_n : consumer side
// Tokens become visible one cycle after being written (no fall-through).
module pe_start_fifo
    import pe_start_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [CNT_W-1:0]      cnt_reg;
    logic [CNT_W-1:0]      cnt_next;
    logic                  empty_n_reg;
    logic                  full_n_reg;
    logic                  wr;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Accepts are qualified by the registered flags, so a write into a full
    // FIFO is refused even if a read frees a slot in the same cycle.
    assign wr = if_write & if_write_ce & full_n_reg;
    assign rd = if_read  & if_read_ce  & empty_n_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (wr && !rd) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end else if (rd && !wr) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg     <= '0;
            empty_n_reg <= 1'b0;
            full_n_reg  <= 1'b1;
        end else begin
            cnt_reg     <= cnt_next;
            empty_n_reg <= (cnt_next != '0);
            full_n_reg  <= (cnt_next != CNT_W'(DEPTH));
        end
    end

    // Newest token sits at entry 0, so the oldest is at entry cnt-1.
    assign rd_addr = (cnt_reg != '0) ? ADDR_WIDTH'(cnt_reg - CNT_W'(1)) : '0;

    pe_start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk      (clk),
        .shift_en (wr & ~reset),
        .din      (if_din),
        .addr     (rd_addr),
        .dout     (if_dout)
    );

    assign if_full_n  = full_n_reg;
    assign if_empty_n = empty_n_reg;

endmodule

// File: doc/pe_start_fifo.md
PE_START_FIFO -- requirements
Module: pe_start_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 1, token width in bits.
REQ-002 Parameter ADDR_WIDTH, default 1, storage index width; SHALL satisfy 2**ADDR_WIDTH >= DEPTH.
REQ-003 Parameter DEPTH, default 2, token capacity; legal range 1..2**ADDR_WIDTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 if_write_ce  input  1  write-side clock enable; a write SHALL NOT occur when low.
REQ-007 if_write  input  1  producer write request.
REQ-008 if_din  input  DATA_WIDTH  token written by the producer.
REQ-009 if_full_n  output  1  registered; high means space is available.
REQ-010 if_read_ce  input  1  read-side clock enable; a read SHALL NOT occur when low.
REQ-011 if_read  input  1  consumer read request.
REQ-012 if_dout  output  DATA_WIDTH  oldest stored token.
REQ-013 if_empty_n  output  1  registered; high means if_dout is valid.

Function
REQ-014 Write accept (wr) SHALL be if_write & if_write_ce & if_full_n; read accept (rd) SHALL be if_read & if_read_ce & if_empty_n.
REQ-015 Occupancy counter cnt (0..DEPTH) SHALL increment on wr&!rd, decrement on rd&!wr, and hold otherwise.
REQ-016 On wr, storage SHALL shift by one entry and place if_din at entry 0, independent of rd.
REQ-017 if_dout SHALL be combinational storage[cnt-1] while cnt>0; when cnt==0, the value is don't-care.
REQ-018 Next-cycle if_empty_n SHALL equal (cnt_next != 0), and next-cycle if_full_n SHALL equal (cnt_next != DEPTH).
REQ-019 Latency: a token written in cycle N SHALL be visible on if_dout with if_empty_n=1 in cycle N+1; there is no fall-through.
REQ-020 Empty with simultaneous if_write and if_read: only the write SHALL be accepted; cnt becomes 1.
REQ-021 Full with simultaneous if_write and if_read: only the read SHALL be accepted; cnt becomes DEPTH-1 and if_full_n rises the next cycle.
REQ-022 Partially full with simultaneous wr and rd: cnt SHALL hold, if_dout SHALL advance to the next-oldest token, and the new token SHALL be retained.
REQ-023 Token order SHALL be strictly FIFO, with no loss or duplication under any pattern of if_write, if_read and the ce inputs.
REQ-024 If if_read_ce=0 or if_write_ce=0, the corresponding side SHALL be fully frozen; the other side operates normally.

Reset
REQ-025 While reset=1 at a clock edge: cnt=0, if_empty_n=0, if_full_n=1; wr and rd in that cycle SHALL be ignored.
REQ-026 Reset asserted mid-operation SHALL discard all stored tokens; storage contents need not be cleared.
REQ-027 The first write SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the default DATA_WIDTH, ADDR_WIDTH and DEPTH constants and the occupancy-count width function.
REQ-029 Storage SHALL be a single sub-module, pe_start_fifo_srl: a write-enabled shift register with an addressed combinational read and no reset.
REQ-030 pe_start_fifo SHALL contain only control logic: accept logic, cnt, flag registers and the read-address derivation.

Verification (DATA_WIDTH=8, DEPTH=2, ADDR_WIDTH=1, both ce=1 unless stated)
REQ-031 Reset for 2 cycles, then idle -> if_empty_n=0 and if_full_n=1 every cycle.
REQ-032 Write 0xA5, then 0x3C; no reads -> cycle+1: empty_n=1, dout=0xA5; cycle+2: full_n=0; a third write of 0x77 is ignored.
REQ-033 From full {0xA5,0x3C}, assert if_write=1 (0x77) and if_read=1 together -> read accepted, write rejected; next cycle dout=0x3C and full_n=1.
REQ-034 With one entry 0x11, assert wr 0x22 and rd together -> cnt stays 1, next dout=0x22; when empty, wr+rd together -> only the write is accepted, next cycle empty_n=1.
REQ-035 Set if_read_ce=0 with if_read=1 while holding 0x5A -> no pop; dout stays 0x5A until if_read_ce=1.
REQ-036 Fill to full, then pulse reset for 1 cycle -> next cycle empty_n=0 and full_n=1; a subsequent write of 0x99 appears on dout one cycle later.
